// File: rtl/clk_div_ctrl_if.sv
// Request bus for clk_div_ctrl: two requesters, each with a valid bit and a
// divide ratio, sharing one per-requester ready vector.
//   req_valid [1:0]      bit i asserted by requester i while its ratio is offered
//   req_ready [1:0]      bit i high when requester i is being accepted
//   req_div0  [DIV_W-1:0] ratio offered by requester 0
//   req_div1  [DIV_W-1:0] ratio offered by requester 1
interface clk_div_ctrl_if #(
  parameter int unsigned DIV_W = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [DIV_W-1:0] req_div0;
  logic [DIV_W-1:0] req_div1;

  modport master (
    output req_valid,
    output req_div0,
    output req_div1,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_div0,
    input  req_div1,
    output req_ready
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Clock divider ratio controller. Arbitrates two requesters (round-robin),
// then applies the accepted ratio to the divider on the next rising edge of
// the divided clock, or after TIMEOUT cycles if no edge arrives.
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      request bus (valid/ready/ratio per requester), slave side
//   clk_div  divided-clock feedback, synchronous to clk
//   div      registered divide ratio driven to the divider
//   busy     a ratio change is pending
//   done     one-cycle pulse per requester when its change is applied
//   err      one-cycle pulse per requester when its ratio (0) is rejected
//   tmo      one-cycle pulse, alongside done, when the apply was forced
module clk_div_ctrl #(
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned DIV_INIT = 1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  clk_div_ctrl_if.slave    bus,
  input  logic             clk_div,
  output logic [DIV_W-1:0] div,
  output logic             busy,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             tmo
);

  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    WAIT_EDGE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             id_q, id_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             rr_last_q, rr_last_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             clk_div_q;

  logic             grant;
  logic [1:0]       ready;
  logic             hs;
  logic [DIV_W-1:0] hs_ratio;
  logic             div_rise;

  // Round-robin grant: with both requesters valid, the one not granted
  // last wins; otherwise whichever is valid.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~rr_last_q;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    ready = '0;
    if (state_q == IDLE && !rst && |bus.req_valid) begin
      ready[grant] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign hs            = |(bus.req_valid & ready);
  assign hs_ratio      = grant ? bus.req_div1 : bus.req_div0;
  assign div_rise      = clk_div & ~clk_div_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pend_d    = pend_q;
    id_d      = id_q;
    timer_d   = timer_q;
    rr_last_d = rr_last_q;
    done_d    = '0;
    err_d     = '0;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          rr_last_d = grant;
          id_d      = grant;
          if (hs_ratio == '0) begin
            err_d[grant] = 1'b1;
          end else if (hs_ratio == div_q) begin
            done_d[grant] = 1'b1;
          end else begin
            state_d = WAIT_EDGE;
            pend_d  = hs_ratio;
            timer_d = '0;
          end
        end
      end
      WAIT_EDGE: begin
        // An edge coinciding with the last timer count counts as an edge,
        // so tmo only fires when no edge was seen.
        if (div_rise || timer_q == TMR_LAST) begin
          div_d        = pend_q;
          done_d[id_q] = 1'b1;
          tmo_d        = ~div_rise;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= DIV_W'(DIV_INIT);
      pend_q    <= '0;
      id_q      <= 1'b0;
      timer_q   <= '0;
      rr_last_q <= 1'b1;
      done_q    <= '0;
      err_q     <= '0;
      tmo_q     <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pend_q    <= pend_d;
      id_q      <= id_d;
      timer_q   <= timer_d;
      rr_last_q <= rr_last_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      clk_div_q <= clk_div;
    end
  end

  assign div  = div_q;
  assign busy = (state_q == WAIT_EDGE);
  assign done = done_q;
  assign err  = err_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int unsigned DIV_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_div;
  logic [DIV_W-1:0] div;
  logic             busy;
  logic [1:0]       done;
  logic [1:0]       err;
  logic             tmo;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  clk_div_ctrl_if #(.DIV_W(DIV_W)) bus ();

  clk_div_ctrl #(
    .DIV_W   (DIV_W),
    .DIV_INIT(1),
    .TIMEOUT (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .clk_div(clk_div),
    .div    (div),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .tmo    (tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    clk_div       = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_div0  = '0;
    bus.req_div1  = '0;
    tick(); tick();
    bus.req_valid = 2'b01;
    #1 check("ready_in_rst", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    check("rst_div", div, 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);

    // Basic change 1 -> 4 on a clk_div rise
    bus.req_valid = 2'b01; bus.req_div0 = 32'd4;
    #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    #1 check("t1_ready_wait", 32'(bus.req_ready), 32'h0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_div_hold", div, 32'd1);
    clk_div = 1'b1;
    tick();
    check("t1_div", div, 32'd4);
    check("t1_done", 32'(done), 32'h1);
    check("t1_tmo", 32'(tmo), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);
    clk_div = 1'b0;
    tick();
    check("t1_done_off", 32'(done), 32'h0);

    // Arbitration from fresh reset: both valid, requester 0 first
    rst = 1'b1; tick(); rst = 1'b0; tick();
    bus.req_valid = 2'b11; bus.req_div0 = 32'd2; bus.req_div1 = 32'd3;
    #1 check("t2_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b10;
    #1 check("t2_ready_wait", 32'(bus.req_ready), 32'h0);
    check("t2_busy", 32'(busy), 32'd1);
    clk_div = 1'b1;
    tick();
    check("t2_div2", div, 32'd2);
    check("t2_done0", 32'(done), 32'h1);
    clk_div = 1'b0;
    #1 check("t2_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    check("t2_busy1", 32'(busy), 32'd1);
    check("t2_done_gap", 32'(done), 32'h0);
    clk_div = 1'b1;
    tick();
    check("t2_div3", div, 32'd3);
    check("t2_done1", 32'(done), 32'h2);
    clk_div = 1'b0;
    tick();

    // Ratio 0 rejected
    bus.req_valid = 2'b10; bus.req_div1 = 32'd0;
    #1 check("t3_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    check("t3_err", 32'(err), 32'h2);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_div", div, 32'd3);
    tick();
    check("t3_err_off", 32'(err), 32'h0);
    check("t3_busy_off", 32'(busy), 32'd0);

    // Timeout with clk_div held low: 8 wait cycles
    bus.req_valid = 2'b01; bus.req_div0 = 32'd5;
    tick();
    bus.req_valid = 2'b00;
    for (int i = 0; i < 7; i++) begin
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_done", 32'(done), 32'h0);
      tick();
    end
    check("t4_busy_last", 32'(busy), 32'd1);
    check("t4_div_hold", div, 32'd3);
    tick();
    check("t4_div", div, 32'd5);
    check("t4_done_pulse", 32'(done), 32'h1);
    check("t4_tmo_pulse", 32'(tmo), 32'd1);
    tick();
    check("t4_tmo_off", 32'(tmo), 32'd0);

    // Edge coinciding with the last timer count: applied as edge, no tmo
    bus.req_valid = 2'b10; bus.req_div1 = 32'd6;
    tick();
    bus.req_valid = 2'b00;
    repeat (7) tick();
    check("t5_busy", 32'(busy), 32'd1);
    clk_div = 1'b1;
    tick();
    check("t5_div", div, 32'd6);
    check("t5_done", 32'(done), 32'h2);
    check("t5_tmo", 32'(tmo), 32'd0);
    clk_div = 1'b0;
    tick();

    // Reset 3 cycles into WAIT_EDGE discards the pending ratio
    bus.req_valid = 2'b01; bus.req_div0 = 32'd7;
    tick();
    bus.req_valid = 2'b00;
    tick(); tick();
    check("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_rst_div", div, 32'd1);
    check("t6_rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();
    check("t6_div", div, 32'd1);
    check("t6_done", 32'(done), 32'h0);
    check("t6_tmo", 32'(tmo), 32'd0);
    check("t6_busy_off", 32'(busy), 32'd0);

    // Equal-ratio request completes without waiting; pointer back at 0
    bus.req_valid = 2'b11; bus.req_div0 = 32'd1; bus.req_div1 = 32'd2;
    #1 check("t7_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    check("t7_done", 32'(done), 32'h1);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_div", div, 32'd1);
    bus.req_valid = 2'b10;
    #1 check("t7_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    check("t7_busy1", 32'(busy), 32'd1);
    clk_div = 1'b1;
    tick();
    check("t7_div2", div, 32'd2);
    check("t7_done1", 32'(done), 32'h2);
    clk_div = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_W, default 32: width of all divide-ratio values.
REQ-002 Parameter DIV_INIT, default 1: divide ratio driven on div after reset.
REQ-003 Parameter TIMEOUT, default 1024: maximum WAIT_EDGE cycles before a forced apply; legal range >= 2.
REQ-004 Clocking and reset SHALL be: one clock, clk; reset rst, synchronous, active-high.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-008 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-009 req_div0  input  DIV_W  ratio requested by requester 0.
REQ-010 req_div1  input  DIV_W  ratio requested by requester 1.
REQ-011 clk_div  input  1  divided-clock feedback from the divider, synchronous to clk.
REQ-012 div  output  DIV_W  registered divide ratio driven to the divider.
REQ-013 busy  output  1  high while a ratio change is pending (WAIT_EDGE).
REQ-014 done  output  2  one-cycle pulse on bit i when requester i's change is applied.
REQ-015 err  output  2  one-cycle pulse on bit i when requester i's request is rejected (ratio 0).
REQ-016 tmo  output  1  one-cycle pulse when an apply was forced by timeout.

Function
REQ-017 FSM states SHALL be IDLE and WAIT_EDGE only.
REQ-018 IDLE: grant SHALL be chosen combinationally among asserted req_valid bits by round-robin; the requester not granted last has priority; req_ready[grant] = 1, other bit 0.
REQ-019 req_ready SHALL be 2'b00 in WAIT_EDGE; there is no combinational path from req_ready to any internal state other than the handshake.
REQ-020 Handshake completes in the cycle req_valid[i] & req_ready[i]; the ratio and requester ID are captured, and the round-robin pointer is updated to i on that edge.
REQ-021 Captured ratio 0: err[i] pulses the next cycle; state stays IDLE; div is unchanged.
REQ-022 Captured ratio equal to current div: done[i] pulses the next cycle; state stays IDLE; no wait.
REQ-023 Any other ratio: next state WAIT_EDGE, busy = 1, and the timer clears to 0.
REQ-024 clk_div_q SHALL register clk_div every cycle in all states; rising edge = clk_div & ~clk_div_q.
REQ-025 WAIT_EDGE, rising edge detected in cycle E: div loads the pending ratio at the end of E; done[i] = 1 in cycle E+1; state returns to IDLE.
REQ-026 WAIT_EDGE, no edge and timer == TIMEOUT-1: same apply as REQ-025, plus tmo = 1 in the same cycle as done; otherwise the timer increments by 1.
REQ-027 Edge and timeout in the same cycle: treated as an edge; tmo = 0.
REQ-028 Requests arriving during WAIT_EDGE SHALL be held off, not dropped; the requester holds req_valid and data stable until accepted.
REQ-029 In the done cycle the state is IDLE, so a new handshake may complete in that same cycle (back-to-back throughput: one change per 2 + wait cycles).
REQ-030 div SHALL change only per REQ-025/026 or reset; ratios are passed through unmodified at full DIV_W.

Reset
REQ-031 On rst: state = IDLE; div = DIV_INIT; req_ready, busy, done, err, tmo = 0 in the cycle after reset; clk_div_q = 0; timer = 0; round-robin pointer = 1, so requester 0 wins first.
REQ-032 rst asserted in WAIT_EDGE SHALL discard the pending ratio without any done, err or tmo pulse.
REQ-033 req_ready SHALL be 0 in any cycle in which rst is high.

Verification
REQ-034 Reset release, req_valid = 2'b01, req_div0 = 4, clk_div toggling -> req_ready = 01 for 1 cycle; busy = 1; div changes 1 -> 4 on the cycle after the first clk_div rise; done = 01 for 1 cycle.
REQ-035 req_valid = 2'b11 held, req_div0 = 2, req_div1 = 3 -> requester 0 is accepted first, then requester 1 on the first IDLE cycle after done; final div = 3.
REQ-036 req_div1 = 0 -> err = 10 for 1 cycle; busy never asserts; div unchanged.
REQ-037 clk_div held at 0, TIMEOUT = 8, request div = 5 -> div = 5 after 8 WAIT_EDGE cycles; done and tmo pulse together.
REQ-038 rst pulsed 3 cycles into WAIT_EDGE -> div = DIV_INIT; no done pulse; the next request is served by requester 0 first.
REQ-039 Request equal to current div (div = 1, req_div0 = 1) -> done = 01 in the next cycle; busy stays 0.
